// File: rtl/ut_control_unit_if.sv
// ---------------------------------------------------------------------------
// ut_control_unit_if
// Bus between the accumulator sequencer and its peers: the shared
// synchronous RAM (address, enable, write strobe, read data), the datapath
// strobes (accumulator load, ALU op), and the carry register (load/clear
// strobes, current flag).
//   master : the control unit (drives address/strobes, reads data/carry)
//   slave  : RAM + datapath + carry register side
// ---------------------------------------------------------------------------
interface ut_control_unit_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_in;
    logic              load_acc;
    logic              alu_op;
    logic              load_carry;
    logic              clear_carry;
    logic              carry;

    modport master (
        output mem_addr, mem_en, mem_we, load_acc, alu_op, load_carry, clear_carry,
        input  mem_data_in, carry
    );

    modport slave (
        input  mem_addr, mem_en, mem_we, load_acc, alu_op, load_carry, clear_carry,
        output mem_data_in, carry
    );
endinterface

// File: rtl/ut_control_unit.sv
// ---------------------------------------------------------------------------
// ut_control_unit
// Sequencer for the 8-bit accumulator unit (NOR, ADD, STA, JCC). Fetches and
// decodes instructions from the shared RAM and drives datapath and carry
// register strobes.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   ce           clock enable; low freezes all state and zeroes strobes
//   bus          ut_control_unit_if.master: RAM address/enable/write,
//                RAM read data, accumulator/ALU strobes, carry strobes/flag
//   pc           program counter (debug)
//   halted       only with UT_HALT_DETECT_EN defined: set by a JCC to its
//                own address executed with carry=0; cleared only by rst
// Optional feature macro: UT_HALT_DETECT_EN
// ---------------------------------------------------------------------------
module ut_control_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    ut_control_unit_if.master bus,
    output logic [ADDR_W-1:0] pc
`ifdef UT_HALT_DETECT_EN
    ,
    output logic              halted
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        ALU    = 3'd3,
        WRITE  = 3'd4,
        JUMP   = 3'd5
    } state_t;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] addr_q;     // last address driven, held in non-memory states
    logic [ADDR_W-1:0] addr_d;
    logic              halt_q;

    // Raw (ungated) strobe decodes
    logic en_r, we_r, la_r, lc_r, cc_r;

    wire [1:0]        opcode  = ir_q[DATA_W-1:DATA_W-2];
    wire [ADDR_W-1:0] operand = ir_q[ADDR_W-1:0];
    wire [1:0]        dec_op  = bus.mem_data_in[DATA_W-1:DATA_W-2];

`ifdef UT_HALT_DETECT_EN
    logic halt_d;
    assign halted = halt_q;
`else
    assign halt_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        en_r    = 1'b0;
        we_r    = 1'b0;
        la_r    = 1'b0;
        lc_r    = 1'b0;
        cc_r    = 1'b0;
`ifdef UT_HALT_DETECT_EN
        halt_d  = halt_q;
`endif
        case (state_q)
            FETCH: begin
                // A halted unit parks here with everything idle.
                if (!halt_q) begin
                    addr_d  = pc_q;
                    en_r    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ir_d = bus.mem_data_in;
                pc_d = pc_q + ADDR_W'(1);
                case (dec_op)
                    OP_NOR, OP_ADD: state_d = READ;
                    OP_STA:         state_d = WRITE;
                    default:        state_d = JUMP;
                endcase
            end
            READ: begin
                addr_d  = operand;
                en_r    = 1'b1;
                state_d = ALU;
            end
            ALU: begin
                la_r    = 1'b1;
                lc_r    = (opcode == OP_ADD);
                state_d = FETCH;
            end
            WRITE: begin
                addr_d  = operand;
                en_r    = 1'b1;
                we_r    = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                cc_r = 1'b1;
                if (!bus.carry) begin
                    pc_d = operand;
`ifdef UT_HALT_DETECT_EN
                    // PC already points past the JCC, so PC-1 is its address.
                    if (operand == pc_q - ADDR_W'(1))
                        halt_d = 1'b1;
`endif
                end
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
`ifdef UT_HALT_DETECT_EN
            halt_q  <= 1'b0;
`endif
        end else if (ce) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
`ifdef UT_HALT_DETECT_EN
            halt_q  <= halt_d;
`endif
        end
    end

    // Strobes are suppressed while stalled or in reset so a frozen state
    // never repeats a strobe and an aborted instruction drops its pending one.
    wire go = ce & ~rst;

    assign bus.mem_addr    = addr_d;
    assign bus.mem_en      = en_r & go;
    assign bus.mem_we      = we_r & go;
    assign bus.load_acc    = la_r & go;
    assign bus.alu_op      = la_r & go & ir_q[DATA_W-2];
    assign bus.load_carry  = lc_r & go;
    assign bus.clear_carry = cc_r & go;
    assign pc              = pc_q;

endmodule

// File: tb/tb_ut_control_unit.sv
module tb_ut_control_unit;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [AW-1:0] pc;
`ifdef UT_HALT_DETECT_EN
    logic          halted;
`endif

    ut_control_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ut_control_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus),
        .pc  (pc)
`ifdef UT_HALT_DETECT_EN
        ,
        .halted (halted)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk)
        if (bus.mem_en && !bus.mem_we)
            bus.mem_data_in <= ram[bus.mem_addr];

    typedef struct {
        logic          ce;
        logic          carry;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic          la;
        logic          op;
        logic          lc;
        logic          cc;
        logic [AW-1:0] pc;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void v(input logic c, input logic cy, input logic en, input logic we,
                              input logic [AW-1:0] a, input logic la, input logic op,
                              input logic lc, input logic cc, input logic [AW-1:0] p);
        vec_t t;
        t.ce = c; t.carry = cy; t.en = en; t.we = we; t.addr = a;
        t.la = la; t.op = op; t.lc = lc; t.cc = cc; t.pc = p;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, " mem_en"},      int'(bus.mem_en),      int'(e.en));
        chk({tag, " mem_we"},      int'(bus.mem_we),      int'(e.we));
        chk({tag, " mem_addr"},    int'(bus.mem_addr),    int'(e.addr));
        chk({tag, " load_acc"},    int'(bus.load_acc),    int'(e.la));
        chk({tag, " alu_op"},      int'(bus.alu_op),      int'(e.op));
        chk({tag, " load_carry"},  int'(bus.load_carry),  int'(e.lc));
        chk({tag, " clear_carry"}, int'(bus.clear_carry), int'(e.cc));
        chk({tag, " pc"},          int'(pc),              int'(e.pc));
    endtask

    vec_t e;

    initial begin
        rst = 1'b1; ce = 1'b1; bus.carry = 1'b0; bus.mem_data_in = '0;
        for (int i = 0; i < (1<<AW); i++) ram[i] = 8'h00;
        ram[0]  = 8'h45;  // ADD 5
        ram[1]  = 8'hD0;  // JCC 0x10 (carry=1: fall through)
        ram[2]  = 8'h8A;  // STA 0x0A
        ram[3]  = 8'hD0;  // JCC 0x10 (carry=0: taken)
        ram[16] = 8'hFF;  // JCC 63
        ram[63] = 8'h07;  // NOR 7, PC wraps to 0

        //  ce cy en we addr  la op lc cc pc
        v(1, 0, 1, 0, 6'h00, 0, 0, 0, 0, 6'h00); // FETCH 0
        v(1, 0, 0, 0, 6'h00, 0, 0, 0, 0, 6'h00); // DECODE
        v(1, 0, 1, 0, 6'h05, 0, 0, 0, 0, 6'h01); // READ 5
        v(1, 0, 0, 0, 6'h05, 1, 1, 1, 0, 6'h01); // ALU ADD
        v(1, 0, 1, 0, 6'h01, 0, 0, 0, 0, 6'h01); // FETCH 1
        v(1, 1, 0, 0, 6'h01, 0, 0, 0, 0, 6'h01); // DECODE
        v(1, 1, 0, 0, 6'h01, 0, 0, 0, 1, 6'h02); // JUMP not taken
        v(1, 0, 1, 0, 6'h02, 0, 0, 0, 0, 6'h02); // FETCH 2
        v(1, 0, 0, 0, 6'h02, 0, 0, 0, 0, 6'h02); // DECODE
        v(0, 0, 0, 0, 6'h0A, 0, 0, 0, 0, 6'h03); // WRITE stalled
        v(0, 0, 0, 0, 6'h0A, 0, 0, 0, 0, 6'h03);
        v(0, 0, 0, 0, 6'h0A, 0, 0, 0, 0, 6'h03);
        v(1, 0, 1, 1, 6'h0A, 0, 0, 0, 0, 6'h03); // WRITE resumes, single pulse
        v(1, 0, 1, 0, 6'h03, 0, 0, 0, 0, 6'h03); // FETCH 3
        v(1, 0, 0, 0, 6'h03, 0, 0, 0, 0, 6'h03); // DECODE
        v(1, 0, 0, 0, 6'h03, 0, 0, 0, 1, 6'h04); // JUMP taken
        v(1, 0, 1, 0, 6'h10, 0, 0, 0, 0, 6'h10); // FETCH 0x10
        v(1, 0, 0, 0, 6'h10, 0, 0, 0, 0, 6'h10); // DECODE
        v(1, 0, 0, 0, 6'h10, 0, 0, 0, 1, 6'h11); // JUMP to 63
        v(1, 0, 1, 0, 6'h3F, 0, 0, 0, 0, 6'h3F); // FETCH 63
        v(1, 0, 0, 0, 6'h3F, 0, 0, 0, 0, 6'h3F); // DECODE, PC wraps
        v(1, 0, 1, 0, 6'h07, 0, 0, 0, 0, 6'h00); // READ 7
        v(1, 0, 0, 0, 6'h07, 1, 0, 0, 0, 6'h00); // ALU NOR
        v(1, 0, 1, 0, 6'h00, 0, 0, 0, 0, 6'h00); // FETCH 0 after wrap

        // Reset state
        repeat (2) @(negedge clk);
        v(1, 0, 0, 0, 6'h00, 0, 0, 0, 0, 6'h00);
        e = vq.pop_back();
        chk_all("reset", e);

        @(negedge clk);
        rst = 1'b0;
        foreach (vq[i]) begin
            ce = vq[i].ce; bus.carry = vq[i].carry;
            #1;
            chk_all($sformatf("vec%0d", i), vq[i]);
            @(negedge clk);
        end

        // Reset in the middle of READ: the ALU step must never happen
        ce = 1'b1; bus.carry = 1'b0;
        #1; chk("pre-abort decode mem_en", int'(bus.mem_en), 0);
        @(negedge clk);
        #1; chk("pre-abort read mem_addr", int'(bus.mem_addr), 5);
        rst = 1'b1;
        #1; chk("abort pc", int'(pc), 0);
        ram[0] = 8'hC5;   // JCC 5
        ram[5] = 8'hC5;   // JCC 5 at address 5: self-jump
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("abort load_acc", int'(bus.load_acc), 0);
            chk("abort mem_en",   int'(bus.mem_en), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-abort fetch mem_en",   int'(bus.mem_en), 1);
        chk("post-abort fetch mem_addr", int'(bus.mem_addr), 0);

        // Self-jump sequence
        repeat (2) @(negedge clk);
        #1; chk("jcc0 clear_carry", int'(bus.clear_carry), 1);
        @(negedge clk);
        #1; chk("fetch5 mem_addr", int'(bus.mem_addr), 5);
            chk("fetch5 pc", int'(pc), 5);
        repeat (2) @(negedge clk);
        #1; chk("self jcc clear_carry", int'(bus.clear_carry), 1);
            chk("self jcc pc", int'(pc), 6);
`ifdef UT_HALT_DETECT_EN
            chk("halted before", int'(halted), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("halted", int'(halted), 1);
            chk("halted mem_en", int'(bus.mem_en), 0);
            chk("halted pc", int'(pc), 5);
        end
`else
        @(negedge clk);
        #1; chk("loop fetch mem_en", int'(bus.mem_en), 1);
            chk("loop fetch mem_addr", int'(bus.mem_addr), 5);
        repeat (3) @(negedge clk);
        #1; chk("loop refetch mem_en", int'(bus.mem_en), 1);
            chk("loop refetch pc", int'(pc), 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ut_control_unit.md
# ut_control_unit

Sequencer for the 8-bit accumulator processing unit (4-instruction set: NOR, ADD, STA, JCC). It fetches and decodes instructions from the shared synchronous RAM and drives the datapath strobes. It is the controlling end of the carry-flag interface: it issues `load_carry`/`clear_carry` to the carry register and reads its `carry_out` to resolve JCC.

## Interface
- `ADDR_W`, default 6: address width; also the PC width and the IR operand field width.
- `DATA_W`, default 8: instruction/data width; opcode = `IR[DATA_W-1:DATA_W-2]`, requires `DATA_W = ADDR_W + 2`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  clock enable; low freezes all state.
- `mem_data_in`  in  DATA_W  RAM read data, valid the cycle after a `mem_en` read.
- `carry`  in  1  current carry flag from the carry register.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_en`  out  1  RAM read/write enable.
- `mem_we`  out  1  RAM write strobe (STA).
- `load_acc`  out  1  accumulator load strobe.
- `alu_op`  out  1  0 = NOR, 1 = ADD; valid whenever `load_acc`=1.
- `load_carry`  out  1  carry register load strobe (ADD only).
- `clear_carry`  out  1  carry register clear strobe (JCC).
- `pc`  out  ADDR_W  program counter, for debug.

## Operation
- Opcodes: 00 NOR, 01 ADD, 10 STA, 11 JCC; operand = `IR[ADDR_W-1:0]`.
- FSM states: FETCH, DECODE, READ, ALU, WRITE, JUMP.
- FETCH: `mem_addr`=PC, `mem_en`=1. Next state is DECODE.
- DECODE: IR <= `mem_data_in`; PC <= PC+1 mod 2^ADDR_W (63 -> 0). NOR/ADD go to READ, STA to WRITE, JCC to JUMP.
- READ: `mem_addr`=operand, `mem_en`=1. Next state is ALU.
- ALU: `load_acc`=1, `alu_op`=IR[6]. `load_carry`=1 for ADD only; NOR leaves carry untouched. Next state is FETCH.
- WRITE: `mem_addr`=operand, `mem_en`=1, `mem_we`=1. Next state is FETCH.
- JUMP: sample `carry` this cycle. If `carry`=0, PC <= operand; if `carry`=1, PC is unchanged (fall through). `clear_carry`=1 in both cases. Next state is FETCH.
- `load_carry` and `clear_carry` are never asserted in the same cycle.
- Outside the states listed above, all strobes are 0 and `mem_addr` holds its last value.

## Timing
- Reset values: state=FETCH, PC=0, IR=0, all strobe outputs 0, `mem_addr`=0. The first FETCH occurs on the first `ce`=1 edge after `rst` falls.
- Latency in `ce`-cycles: NOR/ADD take 4, STA takes 3, JCC takes 3.
- All strobes are combinational decodes of the registered state and IR, and are gated by `ce` (forced to 0 while `ce`=0).
- `ce`=0: state, PC and IR hold. The instruction resumes exactly where it stopped, with no lost or duplicated strobes.
- RAM read latency is fixed at one cycle. `mem_data_in` is sampled only in DECODE (into IR) and in ALU (by the datapath).
- A `carry` change during JUMP from an earlier ADD is already settled, because the ADD's `load_carry` completed at least 3 cycles earlier.
- `rst` asserted mid-instruction aborts it immediately: any pending write or load is dropped, and PC returns to 0.

## Configuration
- Macro `UT_HALT_DETECT_EN`. When defined:
  - Adds output `halted` (1 bit, reset 0).
  - A JCC whose operand equals its own address (PC-1) and that executes with `carry`=0 sets `halted`.
  - While `halted`=1, the FSM stays in FETCH with all strobes 0. Only `rst` clears it.
- Without the macro: no `halted` port, and a self-jump loops forever through FETCH/DECODE/JUMP.

## Test plan
- Reset then fetch: release `rst` with `ce`=1 → `mem_en`=1 and `mem_addr`=0 in cycle 1; `pc`=1 after DECODE.
- ADD: RAM[0]=0x45 → READ shows `mem_addr`=0x05; ALU asserts `load_acc`=1, `alu_op`=1, `load_carry`=1; the next FETCH is at `mem_addr`=1.
- JCC taken vs not taken: RAM[1]=0xD0 with `carry`=0 → `clear_carry`=1 and `pc`=0x10. The same instruction with `carry`=1 → `clear_carry`=1 and `pc`=2.
- STA plus `ce` stall: RAM[2]=0x8A with `ce` held low for 3 cycles during WRITE → exactly one `mem_we` pulse at `mem_addr`=0x0A, and strobes are 0 while `ce`=0.
- PC wrap: NOR at address 63 → the next FETCH is at `mem_addr`=0.
- Reset mid-READ → `load_acc` is never asserted, and the next FETCH is at 0. With `UT_HALT_DETECT_EN` defined, RAM[5]=0xC5 with `carry`=0 → `halted`=1 and `mem_en` stays 0 afterwards.
